mic_frame_buffer: RTL

Collects the streaming microphone samples in the `adc_clk` domain into complete N-point frames for the FFT, which consumes them. Frames are double-buffered (ping-pong banks) and offered over a valid/ready handshake, so sample capture never stalls while a frame waits. The block sits between the microphone sample source and the N-point FFT. It replaces the ad-hoc sample shift register, which had no framing and no handshake.

---
 rtl/mic_frame_buffer_pkg.sv | 23 ++
 rtl/mic_frame_buffer_if.sv | 40 ++++
 rtl/mic_frame_buffer_dc_blocker.sv | 70 +++++++
 rtl/mic_frame_buffer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mic_frame_buffer_pkg.sv
// ---------------------------------------------------------------------------
// mic_frame_pkg
// Shared defaults and types for the microphone frame buffer.
//   DEF_SAMPLE_W / DEF_N_POINTS / DEF_DROP_W : default parameter values
//   sample_t      : one two's-complement microphone sample
//   frame_t       : one N-point frame, element [0] is the oldest sample
//   frame_state_t : presentation state of the buffer (EMPTY / PENDING)
// ---------------------------------------------------------------------------
package mic_frame_pkg;

    localparam int DEF_SAMPLE_W = 32;
    localparam int DEF_N_POINTS = 8;
    localparam int DEF_DROP_W   = 16;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;
    typedef sample_t frame_t [DEF_N_POINTS];

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } frame_state_t;

endpackage

// File: rtl/mic_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// mic_frame_buffer_if
// Sample stream in and frame handshake out of the microphone frame buffer.
//   sample_in / sample_valid : streaming samples, accepted whenever valid
//   frame_out                : presented frame, [0] is the oldest sample
//   frame_valid / frame_ready: frame handshake towards the FFT
// Modports:
//   master : the environment (sample source + frame consumer)
//   slave  : the frame buffer itself
// ---------------------------------------------------------------------------
interface mic_frame_buffer_if
    import mic_frame_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int N_POINTS = DEF_N_POINTS
);

    logic [SAMPLE_W-1:0]                sample_in;
    logic                               sample_valid;
    logic [N_POINTS-1:0][SAMPLE_W-1:0]  frame_out;
    logic                               frame_valid;
    logic                               frame_ready;

    modport master (
        output sample_in,
        output sample_valid,
        output frame_ready,
        input  frame_out,
        input  frame_valid
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  frame_ready,
        output frame_out,
        output frame_valid
    );

endinterface

// File: rtl/mic_frame_buffer_dc_blocker.sv
// ---------------------------------------------------------------------------
// mic_dc_blocker
// Single registered IIR stage removing the DC offset from the sample stream.
// Only instantiated when MIC_FRAME_DC_REMOVE_EN is defined.
//   dc  <= dc + ((x - dc) >>> 4)  on each valid input
//   out <= sat(x - dc)            using the dc value before the update
// Ports:
//   adc_clk, reset           : clock, synchronous active-high reset
//   valid_in, sample_in      : raw sample stream
//   valid_out, sample_out    : filtered stream, one cycle later
// ---------------------------------------------------------------------------
module mic_dc_blocker
    import mic_frame_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                adc_clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                valid_out,
    output logic [SAMPLE_W-1:0] sample_out
);

    localparam int DC_SHIFT = 4;

    logic signed [SAMPLE_W-1:0] dc_r;
    logic signed [SAMPLE_W:0]   diff_s;
    logic                       valid_r;
    logic [SAMPLE_W-1:0]        sample_r;

    // Clamp a one-bit-wider difference back into the sample range.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
        logic [SAMPLE_W-1:0] res;
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
            res = v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            res = v[SAMPLE_W-1:0];
        end
        return res;
    endfunction

    // Sign-extended difference between the new sample and the running DC estimate.
    always_comb begin
        diff_s = {sample_in[SAMPLE_W-1], sample_in} - {dc_r[SAMPLE_W-1], dc_r};
    end

    // DC estimate and filtered output register.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            dc_r     <= '0;
            valid_r  <= 1'b0;
            sample_r <= '0;
        end else begin
            valid_r <= valid_in;
            if (valid_in) begin
                // The estimate is an average of in-range samples, so truncation is safe.
                dc_r     <= dc_r + SAMPLE_W'(diff_s >>> DC_SHIFT);
                sample_r <= sat_sample(diff_s);
            end else begin
                dc_r     <= dc_r;
                sample_r <= sample_r;
            end
        end
    end

    assign valid_out  = valid_r;
    assign sample_out = sample_r;

endmodule

// File: rtl/mic_frame_buffer.sv
// ---------------------------------------------------------------------------
// mic_frame_buffer
// Collects streaming microphone samples into N-point frames using two
// ping-pong banks and presents complete frames over a valid/ready handshake.
// Capture never stalls: if the consumer is late, the newly filled write bank
// is discarded (and counted) while the presented frame stays untouched.
// Configuration macro: MIC_FRAME_DC_REMOVE_EN (adds a DC blocker in front of
// the banks, one extra cycle of input latency).
// Ports:
//   adc_clk        : sample clock, all logic on its rising edge
//   reset          : synchronous active-high reset
//   bus (slave)    : sample_in/sample_valid in, frame_out/frame_valid out,
//                    frame_ready in
//   fill_level     : samples already stored in the write bank
//   dropped_frames : saturating count of discarded frames
// ---------------------------------------------------------------------------
module mic_frame_buffer
    import mic_frame_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int DROP_W   = DEF_DROP_W
) (
    input  logic                      adc_clk,
    input  logic                      reset,
    mic_frame_buffer_if.slave         bus,
    output logic [$clog2(N_POINTS):0] fill_level,
    output logic [DROP_W-1:0]         dropped_frames
);

    localparam int               IDX_W       = $clog2(N_POINTS);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_POINTS - 1);
    localparam logic [0:0]       ST_EMPTY    = 1'(EMPTY);
    localparam logic [0:0]       ST_PENDING  = 1'(PENDING);

    logic                store_valid_s;
    logic [SAMPLE_W-1:0] store_data_s;

`ifdef MIC_FRAME_DC_REMOVE_EN
    mic_dc_blocker #(
        .SAMPLE_W (SAMPLE_W)
    ) u_dc_blocker (
        .adc_clk    (adc_clk),
        .reset      (reset),
        .valid_in   (bus.sample_valid),
        .sample_in  (bus.sample_in),
        .valid_out  (store_valid_s),
        .sample_out (store_data_s)
    );
`else
    assign store_valid_s = bus.sample_valid;
    assign store_data_s  = bus.sample_in;
`endif

    logic [SAMPLE_W-1:0] bank_r [2][N_POINTS];
    logic [0:0]          state_r;
    logic                wr_bank_r;
    logic [IDX_W-1:0]    wr_idx_r;
    logic [DROP_W-1:0]   dropped_r;

    logic                complete_s;
    logic                handshake_s;
    logic [0:0]          state_nx_s;
    logic                flip_s;
    logic                drop_s;

    // Next-state decode: completion, handshake, bank flip and overrun.
    always_comb begin
        complete_s  = store_valid_s && (wr_idx_r == IDX_LAST);
        handshake_s = (state_r == ST_PENDING) && bus.frame_ready;
        state_nx_s  = state_r;
        flip_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_nx_s = ST_PENDING;
                    flip_s     = 1'b1;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_PENDING: begin
                if (complete_s && handshake_s) begin
                    // Old frame leaves and the new one is presented next cycle.
                    state_nx_s = ST_PENDING;
                    flip_s     = 1'b1;
                end else if (complete_s) begin
                    // Overrun: keep the presented frame, refill the write bank.
                    state_nx_s = ST_PENDING;
                    drop_s     = 1'b1;
                end else if (handshake_s) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_PENDING;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // State, bank pointer, write index, bank storage and drop counter.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_r   <= ST_EMPTY;
            wr_bank_r <= 1'b0;
            wr_idx_r  <= '0;
            dropped_r <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_POINTS; i++) begin
                    bank_r[b][i] <= '0;
                end
            end
        end else begin
            state_r <= state_nx_s;
            if (flip_s) begin
                wr_bank_r <= ~wr_bank_r;
            end else begin
                wr_bank_r <= wr_bank_r;
            end
            if (store_valid_s) begin
                bank_r[wr_bank_r][wr_idx_r] <= store_data_s;
                wr_idx_r <= complete_s ? '0 : (wr_idx_r + IDX_W'(1));
            end else begin
                wr_idx_r <= wr_idx_r;
            end
            if (drop_s && (dropped_r != {DROP_W{1'b1}})) begin
                dropped_r <= dropped_r + DROP_W'(1);
            end else begin
                dropped_r <= dropped_r;
            end
        end
    end

    // The presented frame is always the bank not being written.
    always_comb begin
        for (int i = 0; i < N_POINTS; i++) begin
            bus.frame_out[i] = bank_r[~wr_bank_r][i];
        end
    end

    assign bus.frame_valid = (state_r == ST_PENDING);
    assign fill_level      = {1'b0, wr_idx_r};
    assign dropped_frames  = dropped_r;

endmodule
